// File: rtl/reg_rename_if.sv
// Register rename file bus: reservation, commit and read-port signals.
// master drives reservations/commits/read addresses; slave is the rename file.
//   branch_miss          flush all pending reservations
//   rsv/rsv_addr/rob_id  reserve a destination register with a ROB tag
//   cmt_*                per-port commit valid/address/tag/data
//   rd_addr              per-port read address
//   rd_data/rd_tag/rd_filled  per-port read result
//   busy_count           registered count of pending entries
interface reg_rename_if #(
  parameter int unsigned N_RD_PORTS  = 3,
  parameter int unsigned N_CMT_PORTS = 2,
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned RSV_ID_W    = 4
) ();
  logic                                          branch_miss;
  logic                                          rsv;
  logic [REG_ADDR_W-1:0]                         rsv_addr;
  logic [RSV_ID_W-1:0]                           rob_id;
  logic [N_CMT_PORTS-1:0]                        cmt_we;
  logic [N_CMT_PORTS-1:0][REG_ADDR_W-1:0]        cmt_addr;
  logic [N_CMT_PORTS-1:0][RSV_ID_W-1:0]          cmt_tag;
  logic [N_CMT_PORTS-1:0][DATA_W-1:0]            cmt_data;
  logic [N_RD_PORTS-1:0][REG_ADDR_W-1:0]         rd_addr;
  logic [N_RD_PORTS-1:0][DATA_W-1:0]             rd_data;
  logic [N_RD_PORTS-1:0][RSV_ID_W-1:0]           rd_tag;
  logic [N_RD_PORTS-1:0]                         rd_filled;
  logic [REG_ADDR_W:0]                           busy_count;

  modport master (
    output branch_miss, rsv, rsv_addr, rob_id,
    output cmt_we, cmt_addr, cmt_tag, cmt_data,
    output rd_addr,
    input  rd_data, rd_tag, rd_filled, busy_count
  );

  modport slave (
    input  branch_miss, rsv, rsv_addr, rob_id,
    input  cmt_we, cmt_addr, cmt_tag, cmt_data,
    input  rd_addr,
    output rd_data, rd_tag, rd_filled, busy_count
  );
endinterface

// File: rtl/reg_rename_file.sv
// Register rename file: architectural values plus per-entry pending tag
// tracking for an out-of-order core.
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   reg_rename_if.slave (reservation, commit, read ports, busy_count)
// Reads are combinational from state, optionally bypassing same-cycle
// commits that retire the pending producer.
module reg_rename_file #(
  parameter int unsigned N_RD_PORTS  = 3,
  parameter int unsigned N_CMT_PORTS = 2,
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned RSV_ID_W    = 4,
  parameter bit          ZERO_REG    = 1'b1,
  parameter bit          BYPASS      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  reg_rename_if.slave bus
);

  localparam int unsigned NUM_REGS = 1 << REG_ADDR_W;
  localparam int unsigned CNT_W    = REG_ADDR_W + 1;

  logic [DATA_W-1:0]   value_q [NUM_REGS];
  logic [RSV_ID_W-1:0] tag_q   [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q;
  logic [CNT_W-1:0]    busy_q;

  logic [DATA_W-1:0]   value_d [NUM_REGS];
  logic [RSV_ID_W-1:0] tag_d   [NUM_REGS];
  logic [NUM_REGS-1:0] pend_d;
  logic [CNT_W-1:0]    busy_d;

  logic [N_RD_PORTS-1:0][DATA_W-1:0]   rd_data_c;
  logic [N_RD_PORTS-1:0][RSV_ID_W-1:0] rd_tag_c;
  logic [N_RD_PORTS-1:0]               rd_filled_c;

  // Next-state: commits, then flush or reservation, then zero-register clamp.
  always_comb begin
    for (int j = 0; j < int'(NUM_REGS); j++) begin
      value_d[j] = value_q[j];
      tag_d[j]   = tag_q[j];
    end
    pend_d = pend_q;
    busy_d = '0;

    // Ascending order so the highest committing port owns both the value and
    // the retire decision for its address; a later mismatching port restores
    // the pending state an earlier matching port had cleared.
    for (int k = 0; k < int'(N_CMT_PORTS); k++) begin
      if (bus.cmt_we[k]) begin
        value_d[bus.cmt_addr[k]] = bus.cmt_data[k];
        if (pend_q[bus.cmt_addr[k]] && (tag_q[bus.cmt_addr[k]] == bus.cmt_tag[k])) begin
          pend_d[bus.cmt_addr[k]] = 1'b0;
          tag_d[bus.cmt_addr[k]]  = '0;
        end else begin
          pend_d[bus.cmt_addr[k]] = pend_q[bus.cmt_addr[k]];
          tag_d[bus.cmt_addr[k]]  = tag_q[bus.cmt_addr[k]];
        end
      end
    end

    // Flush drops every reservation and ignores a same-cycle reserve;
    // otherwise a reserve overrides any commit retire on the same entry.
    if (bus.branch_miss) begin
      pend_d = '0;
      for (int j = 0; j < int'(NUM_REGS); j++) begin
        tag_d[j] = '0;
      end
    end else if (bus.rsv && !(ZERO_REG && (bus.rsv_addr == '0))) begin
      pend_d[bus.rsv_addr] = 1'b1;
      tag_d[bus.rsv_addr]  = bus.rob_id;
    end

    if (ZERO_REG) begin
      value_d[0] = '0;
      tag_d[0]   = '0;
      pend_d[0]  = 1'b0;
    end

    for (int j = 0; j < int'(NUM_REGS); j++) begin
      busy_d = busy_d + CNT_W'(pend_d[j]);
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < int'(NUM_REGS); j++) begin
        value_q[j] <= '0;
        tag_q[j]   <= '0;
      end
      pend_q <= '0;
      busy_q <= '0;
    end else begin
      for (int j = 0; j < int'(NUM_REGS); j++) begin
        value_q[j] <= value_d[j];
        tag_q[j]   <= tag_d[j];
      end
      pend_q <= pend_d;
      busy_q <= busy_d;
    end
  end

  // Read ports with optional forwarding of a retiring commit.
  always_comb begin
    for (int i = 0; i < int'(N_RD_PORTS); i++) begin
      rd_data_c[i]   = value_q[bus.rd_addr[i]];
      rd_tag_c[i]    = tag_q[bus.rd_addr[i]];
      rd_filled_c[i] = !pend_q[bus.rd_addr[i]];
      if (BYPASS) begin
        for (int k = 0; k < int'(N_CMT_PORTS); k++) begin
          if (bus.cmt_we[k] && (bus.cmt_addr[k] == bus.rd_addr[i])) begin
            if (pend_q[bus.rd_addr[i]] && (tag_q[bus.rd_addr[i]] == bus.cmt_tag[k])) begin
              rd_data_c[i]   = bus.cmt_data[k];
              rd_tag_c[i]    = '0;
              rd_filled_c[i] = 1'b1;
            end else begin
              rd_data_c[i]   = value_q[bus.rd_addr[i]];
              rd_tag_c[i]    = tag_q[bus.rd_addr[i]];
              rd_filled_c[i] = !pend_q[bus.rd_addr[i]];
            end
          end
        end
      end
    end
  end

  assign bus.rd_data    = rd_data_c;
  assign bus.rd_tag     = rd_tag_c;
  assign bus.rd_filled  = rd_filled_c;
  assign bus.busy_count = busy_q;

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed self-checking bench for reg_rename_file (default parameters).
module tb_reg_rename_file;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  reg_rename_if bus ();

  reg_rename_file dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clr();
    bus.branch_miss = 1'b0;
    bus.rsv         = 1'b0;
    bus.rsv_addr    = '0;
    bus.rob_id      = '0;
    bus.cmt_we      = '0;
    bus.cmt_addr    = '0;
    bus.cmt_tag     = '0;
    bus.cmt_data    = '0;
  endtask

  task automatic rsv_set(input logic [4:0] a, input logic [3:0] t);
    bus.rsv      = 1'b1;
    bus.rsv_addr = a;
    bus.rob_id   = t;
  endtask

  task automatic cmt_set(input int p, input logic [4:0] a, input logic [3:0] t, input logic [31:0] d);
    bus.cmt_we[p]   = 1'b1;
    bus.cmt_addr[p] = a;
    bus.cmt_tag[p]  = t;
    bus.cmt_data[p] = d;
  endtask

  task automatic rd3(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    bus.rd_addr[0] = a0;
    bus.rd_addr[1] = a1;
    bus.rd_addr[2] = a2;
  endtask

  // Advance to the next edge and leave inputs settled before the checks.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    clr();
    rd3(5'd0, 5'd5, 5'd31);
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;

    // Reset state
    sample();
    chk("rst_busy", 64'(bus.busy_count), 64'd0);
    chk("rst_data_r5", 64'(bus.rd_data[1]), 64'd0);
    chk("rst_filled", 64'(bus.rd_filled), 64'b111);
    chk("rst_tag_r31", 64'(bus.rd_tag[2]), 64'd0);

    // Reserve r5 tag 3, then commit r5 tag 3 data 0xDEAD
    cyc();
    rsv_set(5'd5, 4'd3);
    sample();
    chk("rsv_not_yet_visible", 64'(bus.rd_filled[1]), 64'd1);
    cyc();
    clr();
    sample();
    chk("r5_pending_filled", 64'(bus.rd_filled[1]), 64'd0);
    chk("r5_pending_tag", 64'(bus.rd_tag[1]), 64'd3);
    chk("r5_busy1", 64'(bus.busy_count), 64'd1);
    cyc();
    cmt_set(0, 5'd5, 4'd3, 32'hDEAD);
    sample();
    chk("r5_bypass_data", 64'(bus.rd_data[1]), 64'hDEAD);
    chk("r5_bypass_filled", 64'(bus.rd_filled[1]), 64'd1);
    chk("r5_bypass_tag", 64'(bus.rd_tag[1]), 64'd0);
    cyc();
    clr();
    sample();
    chk("r5_committed_data", 64'(bus.rd_data[1]), 64'hDEAD);
    chk("r5_committed_filled", 64'(bus.rd_filled[1]), 64'd1);
    chk("r5_busy0", 64'(bus.busy_count), 64'd0);

    // Older commit does not retire a younger reservation
    cyc();
    rd3(5'd7, 5'd4, 5'd0);
    rsv_set(5'd7, 4'd2);
    cyc();
    rsv_set(5'd7, 4'd6);
    cyc();
    clr();
    cmt_set(0, 5'd7, 4'd2, 32'h11);
    sample();
    chk("r7_stale_no_bypass", 64'(bus.rd_filled[0]), 64'd0);
    chk("r7_stale_data_old", 64'(bus.rd_data[0]), 64'd0);
    cyc();
    clr();
    sample();
    chk("r7_value", 64'(bus.rd_data[0]), 64'h11);
    chk("r7_filled", 64'(bus.rd_filled[0]), 64'd0);
    chk("r7_tag", 64'(bus.rd_tag[0]), 64'd6);

    // Same-cycle reserve and commit on idle r4
    cyc();
    rsv_set(5'd4, 4'd9);
    cmt_set(0, 5'd4, 4'd0, 32'h55);
    sample();
    chk("r4_idle_no_bypass", 64'(bus.rd_data[1]), 64'd0);
    cyc();
    clr();
    sample();
    chk("r4_value", 64'(bus.rd_data[1]), 64'h55);
    chk("r4_filled", 64'(bus.rd_filled[1]), 64'd0);
    chk("r4_tag", 64'(bus.rd_tag[1]), 64'd9);
    chk("busy2", 64'(bus.busy_count), 64'd2);

    // Retire r7 and r4 on two ports at once
    cyc();
    cmt_set(0, 5'd7, 4'd6, 32'h77);
    cmt_set(1, 5'd4, 4'd9, 32'h44);
    sample();
    chk("dual_bypass_r7", 64'(bus.rd_data[0]), 64'h77);
    chk("dual_bypass_r4", 64'(bus.rd_data[1]), 64'h44);
    cyc();
    clr();
    sample();
    chk("dual_busy0", 64'(bus.busy_count), 64'd0);
    chk("dual_filled", 64'(bus.rd_filled), 64'b111);

    // Flush with a commit and a reserve in the flush cycle
    cyc();
    rsv_set(5'd1, 4'd1);
    cyc();
    rsv_set(5'd2, 4'd2);
    cyc();
    rsv_set(5'd3, 4'd3);
    cyc();
    clr();
    rd3(5'd1, 5'd2, 5'd3);
    sample();
    chk("pre_flush_busy3", 64'(bus.busy_count), 64'd3);
    chk("pre_flush_filled", 64'(bus.rd_filled), 64'b000);
    cyc();
    bus.branch_miss = 1'b1;
    cmt_set(0, 5'd1, 4'd5, 32'h7);
    rsv_set(5'd9, 4'd4);
    cyc();
    clr();
    sample();
    chk("flush_filled", 64'(bus.rd_filled), 64'b111);
    chk("flush_r1_value", 64'(bus.rd_data[0]), 64'h7);
    chk("flush_tag_r2", 64'(bus.rd_tag[1]), 64'd0);
    chk("flush_busy0", 64'(bus.busy_count), 64'd0);
    rd3(5'd9, 5'd2, 5'd3);
    sample();
    chk("flush_rsv_ignored", 64'(bus.rd_filled[0]), 64'd1);

    // Two ports commit r8 with the same tag: higher port wins
    cyc();
    rd3(5'd8, 5'd0, 5'd10);
    rsv_set(5'd8, 4'd5);
    cyc();
    clr();
    cmt_set(0, 5'd8, 4'd5, 32'hA);
    cmt_set(1, 5'd8, 4'd5, 32'hB);
    sample();
    chk("r8_bypass_data", 64'(bus.rd_data[0]), 64'hB);
    chk("r8_bypass_filled", 64'(bus.rd_filled[0]), 64'd1);
    cyc();
    clr();
    sample();
    chk("r8_stored", 64'(bus.rd_data[0]), 64'hB);
    chk("r8_busy0", 64'(bus.busy_count), 64'd0);

    // Zero register ignores reserve and commit
    cyc();
    rsv_set(5'd10, 4'd1);
    cyc();
    clr();
    rsv_set(5'd0, 4'd7);
    cmt_set(0, 5'd0, 4'd0, 32'hFF);
    sample();
    chk("r0_same_cycle_data", 64'(bus.rd_data[1]), 64'd0);
    cyc();
    clr();
    sample();
    chk("r0_data", 64'(bus.rd_data[1]), 64'd0);
    chk("r0_filled", 64'(bus.rd_filled[1]), 64'd1);
    chk("r0_tag", 64'(bus.rd_tag[1]), 64'd0);
    chk("r0_busy_unchanged", 64'(bus.busy_count), 64'd1);

    // Reset dominates a reserve and a commit in the same cycle
    cyc();
    rst = 1'b1;
    rsv_set(5'd11, 4'd2);
    cmt_set(0, 5'd10, 4'd1, 32'h99);
    cyc();
    rst = 1'b0;
    clr();
    sample();
    chk("rst2_busy", 64'(bus.busy_count), 64'd0);
    chk("rst2_r8_data", 64'(bus.rd_data[0]), 64'd0);
    chk("rst2_r10_data", 64'(bus.rd_data[2]), 64'd0);
    chk("rst2_filled", 64'(bus.rd_filled), 64'b111);
    rd3(5'd11, 5'd5, 5'd1);
    sample();
    chk("rst2_r11_filled", 64'(bus.rd_filled[0]), 64'd1);
    chk("rst2_r5_data", 64'(bus.rd_data[1]), 64'd0);
    chk("rst2_r1_data", 64'(bus.rd_data[2]), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reg_rename_file.md
REG_RENAME_FILE -- requirements
Module: reg_rename_file

Interface
REQ-001 Parameter N_RD_PORTS, default 3, number of read ports.
REQ-002 Parameter N_CMT_PORTS, default 2, number of commit (write) ports.
REQ-003 Parameter REG_ADDR_W, default 5, register address width; 2**REG_ADDR_W entries.
REQ-004 Parameter DATA_W, default 32, data width.
REQ-005 Parameter RSV_ID_W, default 4, reorder-buffer tag width.
REQ-006 Parameter ZERO_REG, default 1, 1 = entry 0 hardwired to zero and never pending.
REQ-007 Parameter BYPASS, default 1, 1 = same-cycle commit forwarded to read ports.
REQ-008 clk  input  1  clock; all state updates on its rising edge.
REQ-009 rst  input  1  reset, synchronous, active-high.
REQ-010 branch_miss  input  1  flush all pending reservations.
REQ-011 rsv  input  1  reserve destination register this cycle.
REQ-012 rsv_addr  input  REG_ADDR_W  destination register being reserved.
REQ-013 rob_id  input  RSV_ID_W  tag assigned to the reservation.
REQ-014 cmt_we  input  N_CMT_PORTS  per-port commit valid.
REQ-015 cmt_addr  input  N_CMT_PORTS x REG_ADDR_W  committed register.
REQ-016 cmt_tag  input  N_CMT_PORTS x RSV_ID_W  tag of the committing instruction.
REQ-017 cmt_data  input  N_CMT_PORTS x DATA_W  committed value.
REQ-018 rd_addr  input  N_RD_PORTS x REG_ADDR_W  read addresses.
REQ-019 rd_data  output  N_RD_PORTS x DATA_W  architectural value.
REQ-020 rd_tag  output  N_RD_PORTS x RSV_ID_W  pending tag; 0 when ready.
REQ-021 rd_filled  output  N_RD_PORTS  1 = value valid, no pending producer.
REQ-022 busy_count  output  REG_ADDR_W+1  registered count of pending entries.

Function
REQ-023 Per entry state SHALL be value[DATA_W], tag[RSV_ID_W], pending[1]; rd_filled = !pending.
REQ-024 Commit on port k SHALL write cmt_data[k] to value unconditionally at the edge.
REQ-025 Commit SHALL clear pending and zero tag only if entry pending and tag == cmt_tag[k]; mismatched tag leaves pending/tag unchanged (younger producer outstanding).
REQ-026 Multiple commit ports to same address in one cycle: highest port index wins for value and tag match.
REQ-027 rsv SHALL set pending=1, tag=rob_id at rsv_addr next cycle.
REQ-028 rsv and commit to same address same cycle: value from commit written, pending/tag from rsv (reservation wins).
REQ-029 branch_miss SHALL clear every pending bit and tag next cycle; commits in that cycle still write value; rsv in that cycle ignored.
REQ-030 ZERO_REG=1: writes and reservations to entry 0 ignored; reads of entry 0 return data 0, tag 0, filled 1.
REQ-031 Reads combinational from current state; a reservation is visible only from the next cycle.
REQ-032 BYPASS=1: if a commit in the current cycle satisfies REQ-025 for rd_addr[i], rd_data[i]=that cmt_data, rd_filled[i]=1, rd_tag[i]=0; BYPASS=0 shows state only.
REQ-033 busy_count SHALL equal the number of pending entries after the edge, one-cycle latency, range 0..2**REG_ADDR_W.
REQ-034 All tag comparisons full width RSV_ID_W, no wrap interpretation.

Reset
REQ-035 rst SHALL dominate all other inputs at the edge.
REQ-036 After reset: all values 0, pending 0, tags 0, busy_count 0, every rd_filled 1, rd_data 0.
REQ-037 Reset mid-operation discards all reservations and in-flight commits of that cycle.

Verification
REQ-038 Reserve r5 tag 3, next cycle commit r5 tag 3 data 0xDEAD -> read r5 cycle after reserve: filled 0, tag 3, busy 1; after commit: data 0xDEAD, filled 1, busy 0.
REQ-039 Reserve r7 tag 2, then r7 tag 6, commit r7 tag 2 data 0x11 -> value 0x11, filled 0, tag 6.
REQ-040 Same cycle rsv r4 tag 9 and commit r4 tag 0 data 0x55 (r4 idle) -> value 0x55, pending 1, tag 9.
REQ-041 Reserve r1,r2,r3, then branch_miss with commit r1 data 0x7 -> all filled 1, r1=0x7, busy 0; rsv in flush cycle has no effect.
REQ-042 Ports 0 and 1 commit r8 tags 5 data 0xA / 0xB, r8 pending tag 5, BYPASS=1 -> same-cycle read r8 = 0xB filled 1; stored 0xB next cycle.
REQ-043 ZERO_REG=1: rsv r0 and commit r0 0xFF -> r0 reads 0, filled 1, busy_count unchanged; then rst -> all state as REQ-036.
